fp_int2fp_pipe: RTL and testbench

Pipelined, parametrised integer-to-FP16 converter for the GPU floating-point path. It accepts IN_WIDTH-bit integers that are signed or unsigned per transaction, and emits IEEE-754 binary16 results (1/5/10, bias 15). Rounding is selectable at build time: round-to-nearest-even or truncate. The block sustains one conversion per cycle behind a valid/ready handshake, and reports inexact and overflow flags alongside each result.

---
 rtl/fp_int2fp_pipe.sv | 180 ++++++++++++++++++
 tb/tb_fp_int2fp_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_int2fp_pipe.sv
// -----------------------------------------------------------------------------
// fp_int2fp_pipe
//
// Converts an IN_WIDTH-bit integer to IEEE-754 binary16. Each transaction
// chooses whether the integer is signed or unsigned. The pipeline has three
// register stages:
//   S1  sign / magnitude
//   S2  leading-one detect and normalise, producing mantissa, guard and sticky
//   S3  round, pack, output register
// All stages share one advance enable. A stalled output therefore freezes the
// whole pipe. It accepts one input per cycle when it is not stalled.
//
// Parameters
//   IN_WIDTH   integer width, 2..32
//   ROUND_RNE  1 = round-to-nearest-even, 0 = truncate toward zero
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word present
//   in_ready   block accepts input this cycle (combinational from out_ready)
//   in_int     integer operand
//   in_signed  1 = in_int is two's complement
//   out_valid  result present
//   out_ready  consumer takes the result this cycle
//   fp_out     binary16 result
//   inexact    result differs from the exact integer
//   overflow   magnitude not representable as a finite FP16 value
// -----------------------------------------------------------------------------
module fp_int2fp_pipe #(
   parameter int IN_WIDTH  = 16,
   parameter bit ROUND_RNE = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_WIDTH-1:0] in_int,
   input  logic                in_signed,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [15:0]         fp_out,
   output logic                inexact,
   output logic                overflow
);

   // The magnitude is padded with 12 zero bits so that the mantissa and guard
   // fields exist even for very narrow inputs.
   localparam int          EW      = IN_WIDTH + 12;
   localparam logic [5:0]  MSB_IDX = 6'(IN_WIDTH - 1);

   logic adv;

   // ---------------- S1: sign / magnitude ----------------
   logic                s1_valid_q;
   logic                s1_sign_q,  s1_sign_d;
   logic [IN_WIDTH-1:0] s1_mag_q,   s1_mag_d;

   // ---------------- S2: normalised fields ----------------
   logic                s2_valid_q;
   logic                s2_sign_q;
   logic                s2_zero_q,   s2_zero_d;
   logic [5:0]          s2_p_q,      s2_p_d;
   logic [9:0]          s2_mant_q,   s2_mant_d;
   logic                s2_guard_q,  s2_guard_d;
   logic                s2_sticky_q, s2_sticky_d;

   // ---------------- S3: outputs ----------------
   logic                out_valid_q;
   logic [15:0]         fp_out_q,   fp_out_d;
   logic                inexact_q,  inexact_d;
   logic                overflow_q, overflow_d;

   logic [5:0]          shamt;
   logic [EW-1:0]       norm;
   logic [6:0]          exp_raw;
   logic [6:0]          exp_rnd;
   logic                round_up;
   logic [10:0]         mant_sum;

   // The pipe advances whenever the output register is free or being drained.
   assign adv      = out_ready | ~out_valid_q;
   assign in_ready = adv;

   // Negating in IN_WIDTH bits maps -2^(IN_WIDTH-1) onto 2^(IN_WIDTH-1). That
   // value is exactly the unsigned magnitude, so the result never wraps.
   always_comb begin
      s1_sign_d = in_signed & in_int[IN_WIDTH-1];
      s1_mag_d  = s1_sign_d ? (~in_int + {{(IN_WIDTH-1){1'b0}}, 1'b1}) : in_int;
   end

   // Find the leading one, then shift it to the top of the padded vector.
   // After the shift, the top bit is set exactly when the magnitude is
   // nonzero.
   always_comb begin
      s2_p_d = 6'd0;
      for (int i = 0; i < IN_WIDTH; i++) begin
         if (s1_mag_q[i]) s2_p_d = 6'(i);
      end
      shamt       = MSB_IDX - s2_p_d;
      norm        = {s1_mag_q, 12'b0} << shamt;
      s2_zero_d   = ~norm[EW-1];
      s2_mant_d   = norm[EW-2 -: 10];
      s2_guard_d  = norm[EW-12];
      s2_sticky_d = |norm[EW-13:0];
   end

   // Round and pack.
   always_comb begin
      exp_raw    = {1'b0, s2_p_q} + 7'd15;
      round_up   = s2_guard_q & (s2_sticky_q | s2_mant_q[0]);
      mant_sum   = {1'b0, s2_mant_q} + {10'b0, round_up};
      // A mantissa carry-out leaves mant_sum[9:0] at zero, so only the
      // exponent needs to be adjusted.
      exp_rnd    = exp_raw + {6'b0, mant_sum[10]};
      fp_out_d   = 16'h0000;
      inexact_d  = 1'b0;
      overflow_d = 1'b0;
      if (!s2_zero_q) begin
         inexact_d = s2_guard_q | s2_sticky_q;
         if (ROUND_RNE) begin
            if (exp_rnd >= 7'd31) begin
               fp_out_d   = {s2_sign_q, 5'h1F, 10'h000};
               overflow_d = 1'b1;
               inexact_d  = 1'b1;
            end else begin
               fp_out_d = {s2_sign_q, exp_rnd[4:0], mant_sum[9:0]};
            end
         end else begin
            if (s2_p_q >= 6'd16) begin
               fp_out_d   = {s2_sign_q, 15'h7BFF};
               overflow_d = 1'b1;
               inexact_d  = 1'b1;
            end else begin
               fp_out_d = {s2_sign_q, exp_raw[4:0], s2_mant_q};
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_mag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_sign_q   <= 1'b0;
         s2_zero_q   <= 1'b1;
         s2_p_q      <= 6'd0;
         s2_mant_q   <= 10'd0;
         s2_guard_q  <= 1'b0;
         s2_sticky_q <= 1'b0;
         out_valid_q <= 1'b0;
         fp_out_q    <= 16'h0000;
         inexact_q   <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (adv) begin
         s1_valid_q  <= in_valid;
         s1_sign_q   <= s1_sign_d;
         s1_mag_q    <= s1_mag_d;
         s2_valid_q  <= s1_valid_q;
         s2_sign_q   <= s1_sign_q;
         s2_zero_q   <= s2_zero_d;
         s2_p_q      <= s2_p_d;
         s2_mant_q   <= s2_mant_d;
         s2_guard_q  <= s2_guard_d;
         s2_sticky_q <= s2_sticky_d;
         out_valid_q <= s2_valid_q;
         fp_out_q    <= fp_out_d;
         inexact_q   <= inexact_d;
         overflow_q  <= overflow_d;
      end
   end

   assign out_valid = out_valid_q;
   assign fp_out    = fp_out_q;
   assign inexact   = inexact_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_fp_int2fp_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_int2fp_pipe
//
// Four builds of the converter run in lock-step on the same stimulus:
//   instance 0  IN_WIDTH = 16, RNE
//   instance 1  IN_WIDTH = 16, truncate
//   instance 2  IN_WIDTH = 32, RNE
//   instance 3  IN_WIDTH = 32, truncate
// Expected results come from an arithmetic reference model. They are queued
// per instance when an input is accepted, and compared when that instance
// delivers a result.
// -----------------------------------------------------------------------------
module tb_fp_int2fp_pipe;

   typedef struct {
      logic [17:0] res;    // {overflow, inexact, fp16}
      int          acc;    // cycle in which the input was presented and accepted
   } entry_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_int;
   logic        in_signed;
   logic        out_ready;

   logic        in_ready_v  [4];
   logic        out_valid_v [4];
   logic [15:0] fp_v        [4];
   logic        inx_v       [4];
   logic        ovf_v       [4];

   int          width_c [4] = '{16, 16, 32, 32};
   bit          rne_c   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   entry_t      sb [4][$];
   int          checks = 0;
   int          passes = 0;
   int          fails  = 0;
   int          cycle  = 0;
   int          pops0  = 0;
   bit          lat_check = 1'b0;
   bit          rand_mode = 1'b0;
   bit          last_acc  = 1'b0;

   logic [31:0] dir_vals [13] = '{32'd1, 32'd2049, 32'd2051, 32'd65535,
                                  32'h0000FFFF, 32'h00008000, 32'h00000000,
                                  32'd65504, 32'd65520, 32'h00010000,
                                  32'h80000000, 32'hFFFFFFFF, 32'hFFFF8000};
   bit          dir_sgn  [13] = '{1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b1, 1'b1,
                                  1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b1, 1'b1};

   always #5 clk = ~clk;

   fp_int2fp_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
      .in_int(in_int[15:0]), .in_signed(in_signed), .out_valid(out_valid_v[0]),
      .out_ready(out_ready), .fp_out(fp_v[0]), .inexact(inx_v[0]), .overflow(ovf_v[0]));

   fp_int2fp_pipe #(.IN_WIDTH(16), .ROUND_RNE(1'b0)) u_w16_trunc (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
      .in_int(in_int[15:0]), .in_signed(in_signed), .out_valid(out_valid_v[1]),
      .out_ready(out_ready), .fp_out(fp_v[1]), .inexact(inx_v[1]), .overflow(ovf_v[1]));

   fp_int2fp_pipe #(.IN_WIDTH(32), .ROUND_RNE(1'b1)) u_w32_rne (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
      .in_int(in_int), .in_signed(in_signed), .out_valid(out_valid_v[2]),
      .out_ready(out_ready), .fp_out(fp_v[2]), .inexact(inx_v[2]), .overflow(ovf_v[2]));

   fp_int2fp_pipe #(.IN_WIDTH(32), .ROUND_RNE(1'b0)) u_w32_trunc (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[3]),
      .in_int(in_int), .in_signed(in_signed), .out_valid(out_valid_v[3]),
      .out_ready(out_ready), .fp_out(fp_v[3]), .inexact(inx_v[3]), .overflow(ovf_v[3]));

   // Reference: the integer is reduced to an 11-bit significand q and an
   // exact remainder. Rounding compares the remainder with half an ulp.
   function automatic logic [17:0] model(input logic [31:0] x, input int w,
                                         input bit sgn, input bit rne);
      longint unsigned one, v, m, q, rem, half;
      int   p;
      bit   s, inx, ovf;
      logic [4:0] e;
      one = 1;
      v   = {32'b0, x} & ((one << w) - one);
      s   = sgn && (((v >> (w - 1)) & one) == one);
      m   = s ? ((one << w) - v) : v;
      if (m == 0) return 18'h0;
      p = 0;
      for (int i = 0; i < w; i++) if (((m >> i) & one) == one) p = i;
      rem = 0; half = 0;
      if (p <= 10) q = m << (10 - p);
      else begin
         q    = m >> (p - 10);
         rem  = m - (q << (p - 10));
         half = one << (p - 11);
      end
      inx = (rem != 0);
      ovf = 1'b0;
      if (rne) begin
         if (p > 10 && (rem > half || (rem == half && q[0]))) q = q + 1;
         if (q == 2048) begin q = 1024; p = p + 1; end
         if (p + 15 >= 31) return {1'b1, 1'b1, s, 5'h1F, 10'h000};
      end else if (p >= 16) begin
         return {1'b1, 1'b1, s, 15'h7BFF};
      end
      e = 5'(p + 15);
      return {ovf, inx, s, e, q[9:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // One clock cycle. At the negedge it compares outputs that will transfer
   // and notes whether the input will be accepted. After the posedge it queues
   // expectations for an accepted input.
   task automatic tick();
      bit     acc;
      int     acc_cyc;
      entry_t e;
      @(negedge clk);
      acc = rst_n && in_valid && in_ready_v[0];
      if (rst_n && out_ready) begin
         for (int k = 0; k < 4; k++) begin
            if (out_valid_v[k]) begin
               check($sformatf("i%0d_sb_nonempty", k), 32'(sb[k].size() != 0), 32'd1);
               if (sb[k].size() != 0) begin
                  e = sb[k].pop_front();
                  $display("t=%0t i%0d out fp=%h inx=%b ovf=%b exp=%h", $time, k,
                           fp_v[k], inx_v[k], ovf_v[k], e.res);
                  check($sformatf("i%0d_result", k), {14'b0, ovf_v[k], inx_v[k], fp_v[k]},
                        {14'b0, e.res});
                  if (k == 0) begin
                     pops0++;
                     if (lat_check) check("latency", 32'(cycle - e.acc), 32'd3);
                  end
               end
            end
         end
      end
      acc_cyc = cycle;
      @(posedge clk);
      cycle++;
      #1;
      last_acc = acc;
      if (acc) begin
         for (int k = 0; k < 4; k++) begin
            e.res = model(in_int, width_c[k], in_signed, rne_c[k]);
            e.acc = acc_cyc;
            sb[k].push_back(e);
         end
      end
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [31:0] x, input bit sgn);
      int n;
      n         = 0;
      in_valid  = 1'b1;
      in_int    = x;
      in_signed = sgn;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 200);
      check("accept", 32'(last_acc), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      logic [15:0] held;
      int          p_before;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_int    = 32'h0;
      in_signed = 1'b0;
      out_ready = 1'b1;
      idle(2);

      // Reset state.
      check("rst_out_valid", 32'(out_valid_v[0]), 32'd0);
      check("rst_fp_out", 32'(fp_v[0]), 32'h0);
      check("rst_flags", {30'b0, inx_v[0], ovf_v[0]}, 32'd0);
      check("rst_in_ready", 32'(in_ready_v[0]), 32'd1);
      rst_n     = 1'b1;
      lat_check = 1'b1;

      // Directed values, back-to-back.
      for (int i = 0; i < 13; i++) send(dir_vals[i], dir_sgn[i]);
      idle(6);

      // Backpressure mid-stream, with garbage offered while stalled.
      for (int i = 0; i < 4; i++) send(32'(1000 + 777 * i), 1'b0);
      lat_check = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_int    = 32'h0000_1234;
      in_signed = 1'b0;
      held      = fp_v[0];
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_out_valid", 32'(out_valid_v[0]), 32'd1);
         check("stall_fp_stable", 32'(fp_v[0]), 32'(held));
         check("stall_in_ready", 32'(in_ready_v[0]), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) send(32'(70000 + 4097 * i), 1'b1);
      idle(6);

      // Random out_ready and random operands.
      rand_mode = 1'b1;
      for (int i = 0; i < 40; i++)
         send($urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)));
      rand_mode = 1'b0;
      out_ready = 1'b1;
      idle(8);

      // Asynchronous reset with three conversions in flight.
      send(32'd5, 1'b0);
      send(32'd6, 1'b0);
      send(32'd7, 1'b0);
      check("pre_rst_out_valid", 32'(out_valid_v[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(out_valid_v[0]), 32'd0);
      check("async_rst_fp_out", 32'(fp_v[0]), 32'h0);
      check("async_rst_flags", {30'b0, inx_v[0], ovf_v[0]}, 32'd0);
      check("async_rst_in_ready", 32'(in_ready_v[0]), 32'd1);
      for (int k = 0; k < 4; k++) sb[k].delete();
      idle(2);
      rst_n     = 1'b1;
      lat_check = 1'b1;
      p_before  = pops0;
      send(32'hFFFF_FFFD, 1'b1);
      idle(6);
      check("post_rst_one_result", 32'(pops0 - p_before), 32'd1);

      for (int k = 0; k < 4; k++)
         check($sformatf("i%0d_drained", k), 32'(sb[k].size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
